// File: rtl/mips_wb_pkg.sv
// Shared encodings and default widths for the MIPS write-back stage.
package mips_wb_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 5;

    // Write-back source select
    localparam logic [2:0] WB_ALU  = 3'd0;
    localparam logic [2:0] WB_MEM  = 3'd1;
    localparam logic [2:0] WB_LINK = 3'd2;
    localparam logic [2:0] WB_HI   = 3'd3;
    localparam logic [2:0] WB_LO   = 3'd4;

    // Load type
    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LH  = 3'd1;
    localparam logic [2:0] LD_LHU = 3'd2;
    localparam logic [2:0] LD_LB  = 3'd3;
    localparam logic [2:0] LD_LBU = 3'd4;

endpackage

// File: rtl/writeback_unit_load_align.sv
// Sub-word load extractor: picks the byte/halfword lane addressed by the
// offset and sign- or zero-extends it. Lanes are defined for a 32-bit word.
module load_align
    import mips_wb_pkg::*;
#(
    parameter int BIG_ENDIAN = 1
) (
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  load_type_i,
    output logic [31:0] data_o
);

    logic [1:0]  byte_lane;
    logic        half_lane;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Big-endian: offset 0 is the most significant lane. off_i[0] is ignored
    // for halfwords because misaligned accesses trap before reaching here.
    assign byte_lane = (BIG_ENDIAN != 0) ? ~off_i    : off_i;
    assign half_lane = (BIG_ENDIAN != 0) ? ~off_i[1] : off_i[1];
    assign byte_val  = word_i[{byte_lane, 3'b000} +: 8];
    assign half_val  = word_i[{half_lane, 4'b0000} +: 16];

    always_comb begin
        case (load_type_i)
            LD_LH:   data_o = {{16{half_val[15]}}, half_val};
            LD_LHU:  data_o = {16'h0000, half_val};
            LD_LB:   data_o = {{24{byte_val[7]}}, byte_val};
            LD_LBU:  data_o = {24'h000000, byte_val};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// MEM/WB pipeline register, architectural HI/LO and register-file write-back
// select with load alignment; feeds the register file and forwarding unit.
module writeback_unit
    import mips_wb_pkg::*;
#(
    parameter int DATA_W           = DATA_W_DEF,
    parameter int REG_ADDR_W       = REG_ADDR_W_DEF,
    parameter int BIG_ENDIAN       = 1,
    parameter int ZERO_REG_PROTECT = 1
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic                  In_Valid,
    input  logic                  In_RegWrite,
    input  logic [REG_ADDR_W-1:0] In_WriteReg,
    input  logic [2:0]            In_WbSel,
    input  logic [2:0]            In_LoadType,
    input  logic [DATA_W-1:0]     In_AluResult,
    input  logic [DATA_W-1:0]     In_MemData,
    input  logic [DATA_W-1:0]     In_PCPlusFour,
    input  logic                  In_HiLoWrite,
    input  logic [DATA_W-1:0]     In_Hi,
    input  logic [DATA_W-1:0]     In_Lo,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0]     RegData_out,
    output logic [DATA_W-1:0]     Hi,
    output logic [DATA_W-1:0]     Lo
);

    logic                  valid_q,        valid_d;
    logic                  reg_write_q,    reg_write_d;
    logic [REG_ADDR_W-1:0] write_reg_q,    write_reg_d;
    logic [2:0]            wb_sel_q,       wb_sel_d;
    logic [2:0]            load_type_q,    load_type_d;
    logic [DATA_W-1:0]     alu_result_q,   alu_result_d;
    logic [DATA_W-1:0]     mem_data_q,     mem_data_d;
    logic [DATA_W-1:0]     pc_plus_four_q, pc_plus_four_d;
    logic                  hilo_write_q,   hilo_write_d;
    logic [DATA_W-1:0]     hi_new_q,       hi_new_d;
    logic [DATA_W-1:0]     lo_new_q,       lo_new_d;
    logic [DATA_W-1:0]     hi_q,           lo_q;

    logic              hilo_commit;
    logic              sel_legal;
    logic              reg0_blocked;
    logic [DATA_W-1:0] load_data;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path
        // through this block can leave one unassigned and infer a latch.
        valid_d        = valid_q;
        reg_write_d    = reg_write_q;
        write_reg_d    = write_reg_q;
        wb_sel_d       = wb_sel_q;
        load_type_d    = load_type_q;
        alu_result_d   = alu_result_q;
        mem_data_d     = mem_data_q;
        pc_plus_four_d = pc_plus_four_q;
        hilo_write_d   = hilo_write_q;
        hi_new_d       = hi_new_q;
        lo_new_d       = lo_new_q;
        if (Flush) begin
            valid_d        = 1'b0;
            reg_write_d    = 1'b0;
            write_reg_d    = '0;
            wb_sel_d       = '0;
            load_type_d    = '0;
            alu_result_d   = '0;
            mem_data_d     = '0;
            pc_plus_four_d = '0;
            hilo_write_d   = 1'b0;
            hi_new_d       = '0;
            lo_new_d       = '0;
        end else if (!Stall) begin
            valid_d        = In_Valid;
            reg_write_d    = In_RegWrite;
            write_reg_d    = In_WriteReg;
            wb_sel_d       = In_WbSel;
            load_type_d    = In_LoadType;
            alu_result_d   = In_AluResult;
            mem_data_d     = In_MemData;
            pc_plus_four_d = In_PCPlusFour;
            hilo_write_d   = In_HiLoWrite;
            hi_new_d       = In_Hi;
            lo_new_d       = In_Lo;
        end
    end

    // HI/LO commit on the edge where the entry leaves WB, so a stalled
    // mult updates exactly once and the following mfhi sees the result.
    assign hilo_commit = valid_q & hilo_write_q & (Flush | ~Stall);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            valid_q        <= 1'b0;
            reg_write_q    <= 1'b0;
            write_reg_q    <= '0;
            wb_sel_q       <= '0;
            load_type_q    <= '0;
            alu_result_q   <= '0;
            mem_data_q     <= '0;
            pc_plus_four_q <= '0;
            hilo_write_q   <= 1'b0;
            hi_new_q       <= '0;
            lo_new_q       <= '0;
            hi_q           <= '0;
            lo_q           <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            valid_q        <= valid_d;
            reg_write_q    <= reg_write_d;
            write_reg_q    <= write_reg_d;
            wb_sel_q       <= wb_sel_d;
            load_type_q    <= load_type_d;
            alu_result_q   <= alu_result_d;
            mem_data_q     <= mem_data_d;
            pc_plus_four_q <= pc_plus_four_d;
            hilo_write_q   <= hilo_write_d;
            hi_new_q       <= hi_new_d;
            lo_new_q       <= lo_new_d;
            if (hilo_commit) begin
                hi_q <= hi_new_q;
                lo_q <= lo_new_q;
            end
        end
    end

    load_align #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_load_align (
        .word_i      (mem_data_q),
        .off_i       (alu_result_q[1:0]),
        .load_type_i (load_type_q),
        .data_o      (load_data)
    );

    assign sel_legal    = (wb_sel_q <= WB_LO);
    assign reg0_blocked = (ZERO_REG_PROTECT != 0) && (write_reg_q == '0);

    assign RegWrite = valid_q & reg_write_q & sel_legal & ~reg0_blocked;
    assign WriteReg = write_reg_q;
    assign Hi       = hi_q;
    assign Lo       = lo_q;

    always_comb begin
        case (wb_sel_q)
            WB_ALU:  RegData_out = alu_result_q;
            WB_MEM:  RegData_out = load_data;
            WB_LINK: RegData_out = pc_plus_four_q;
            WB_HI:   RegData_out = hi_q;
            WB_LO:   RegData_out = lo_q;
            default: RegData_out = '0;
        endcase
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: vector table for select/alignment plus
// hand sequences for HI/LO timing, stall/flush and asynchronous reset.
module tb_writeback_unit;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Stall, Flush;
    logic        In_Valid, In_RegWrite, In_HiLoWrite;
    logic [4:0]  In_WriteReg;
    logic [2:0]  In_WbSel, In_LoadType;
    logic [31:0] In_AluResult, In_MemData, In_PCPlusFour, In_Hi, In_Lo;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] RegData_out, Hi, Lo;

    int tests_run = 0;
    int tests_failed = 0;

    writeback_unit dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .Stall         (Stall),
        .Flush         (Flush),
        .In_Valid      (In_Valid),
        .In_RegWrite   (In_RegWrite),
        .In_WriteReg   (In_WriteReg),
        .In_WbSel      (In_WbSel),
        .In_LoadType   (In_LoadType),
        .In_AluResult  (In_AluResult),
        .In_MemData    (In_MemData),
        .In_PCPlusFour (In_PCPlusFour),
        .In_HiLoWrite  (In_HiLoWrite),
        .In_Hi         (In_Hi),
        .In_Lo         (In_Lo),
        .RegWrite      (RegWrite),
        .WriteReg      (WriteReg),
        .RegData_out   (RegData_out),
        .Hi            (Hi),
        .Lo            (Lo)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [2:0]  wb_sel;
        logic [2:0]  load_type;
        logic [31:0] alu;
        logic        reg_write;
        logic [4:0]  write_reg;
        logic        exp_rw;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic drive(input logic valid, input logic rw, input logic [4:0] wr,
                         input logic [2:0] sel, input logic [2:0] lt,
                         input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc,
                         input logic hlw, input logic [31:0] hi, input logic [31:0] lo);
        In_Valid = valid; In_RegWrite = rw; In_WriteReg = wr; In_WbSel = sel;
        In_LoadType = lt; In_AluResult = alu; In_MemData = mem; In_PCPlusFour = pc;
        In_HiLoWrite = hlw; In_Hi = hi; In_Lo = lo;
    endtask

    task automatic nop();
        drive(1'b0, 1'b0, 5'd0, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset_n = 1'b0; Stall = 1'b0; Flush = 1'b0;
        nop();

        // Table: {sel, load type, alu/offset, regwrite, dest, exp RegWrite, exp data}
        vecs[0]  = '{3'd1, 3'd3, 32'h0000_1000, 1'b1, 5'd7, 1'b1, 32'hFFFF_FF80}; // LB off0
        vecs[1]  = '{3'd1, 3'd4, 32'h0000_1000, 1'b1, 5'd7, 1'b1, 32'h0000_0080}; // LBU off0
        vecs[2]  = '{3'd1, 3'd3, 32'h0000_1002, 1'b1, 5'd7, 1'b1, 32'h0000_007F}; // LB off2
        vecs[3]  = '{3'd1, 3'd1, 32'h0000_1000, 1'b1, 5'd7, 1'b1, 32'hFFFF_80FF}; // LH off0
        vecs[4]  = '{3'd1, 3'd2, 32'h0000_1002, 1'b1, 5'd7, 1'b1, 32'h0000_7F01}; // LHU off2
        vecs[5]  = '{3'd1, 3'd0, 32'h0000_1003, 1'b1, 5'd7, 1'b1, 32'h80FF_7F01}; // LW ignores off
        vecs[6]  = '{3'd1, 3'd3, 32'h0000_1001, 1'b1, 5'd7, 1'b1, 32'hFFFF_FFFF}; // LB off1
        vecs[7]  = '{3'd1, 3'd4, 32'h0000_1003, 1'b1, 5'd7, 1'b1, 32'h0000_0001}; // LBU off3
        vecs[8]  = '{3'd1, 3'd2, 32'h0000_1001, 1'b1, 5'd7, 1'b1, 32'h0000_80FF}; // LHU off[0] ignored
        vecs[9]  = '{3'd1, 3'd7, 32'h0000_1002, 1'b1, 5'd7, 1'b1, 32'h80FF_7F01}; // illegal type -> LW
        vecs[10] = '{3'd0, 3'd0, 32'h1234_5678, 1'b1, 5'd5, 1'b1, 32'h1234_5678}; // ALU
        vecs[11] = '{3'd0, 3'd0, 32'hDEAD_BEEF, 1'b1, 5'd0, 1'b0, 32'hDEAD_BEEF}; // r0 suppressed
        vecs[12] = '{3'd6, 3'd0, 32'h1111_2222, 1'b1, 5'd8, 1'b0, 32'h0000_0000}; // illegal sel 6
        vecs[13] = '{3'd0, 3'd0, 32'h3333_4444, 1'b0, 5'd9, 1'b0, 32'h3333_4444}; // no regwrite

        // Reset state
        #2;
        check("reset_rw",   {31'h0, RegWrite}, 32'h0);
        check("reset_data", RegData_out, 32'h0);
        check("reset_wreg", {27'h0, WriteReg}, 32'h0);
        check("reset_hi",   Hi, 32'h0);
        check("reset_lo",   Lo, 32'h0);
        @(negedge Clk);
        Reset_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            drive(1'b1, vecs[i].reg_write, vecs[i].write_reg, vecs[i].wb_sel, vecs[i].load_type,
                  vecs[i].alu, 32'h80FF_7F01, 32'h0, 1'b0, 32'h0, 32'h0);
            step();
            check($sformatf("vec%0d_rw", i), {31'h0, RegWrite}, {31'h0, vecs[i].exp_rw});
            check($sformatf("vec%0d_data", i), RegData_out, vecs[i].exp_data);
            check($sformatf("vec%0d_wreg", i), {27'h0, WriteReg}, {27'h0, vecs[i].write_reg});
        end

        // Link write (jal)
        drive(1'b1, 1'b1, 5'd31, 3'd2, 3'd0, 32'h0, 32'h0, 32'h0040_0024, 1'b0, 32'h0, 32'h0);
        step();
        check("link_rw",   {31'h0, RegWrite}, 32'h1);
        check("link_wreg", {27'h0, WriteReg}, 32'd31);
        check("link_data", RegData_out, 32'h0040_0024);

        // mult followed by mfhi r2
        drive(1'b1, 1'b0, 5'd0, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h1, 32'hFFFF_FFFE);
        step();
        check("mult_rw",      {31'h0, RegWrite}, 32'h0);
        check("mult_hi_old",  Hi, 32'h0);
        drive(1'b1, 1'b1, 5'd2, 3'd3, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        step();
        check("mfhi_rw",   {31'h0, RegWrite}, 32'h1);
        check("mfhi_wreg", {27'h0, WriteReg}, 32'd2);
        check("mfhi_data", RegData_out, 32'h0000_0001);
        check("mfhi_lo",   Lo, 32'hFFFF_FFFE);
        nop();
        step();
        check("after_lo", Lo, 32'hFFFF_FFFE);
        check("after_hi", Hi, 32'h0000_0001);

        // ALU write to r9 that also writes HI/LO, then stalled for 3 cycles
        drive(1'b1, 1'b1, 5'd9, 3'd0, 3'd0, 32'h0000_AAAA, 32'h0, 32'h0, 1'b1, 32'h55, 32'h66);
        step();
        check("stall_c0_rw",   {31'h0, RegWrite}, 32'h1);
        check("stall_c0_data", RegData_out, 32'h0000_AAAA);
        check("stall_c0_hi",   Hi, 32'h1);
        Stall = 1'b1;
        drive(1'b1, 1'b1, 5'd10, 3'd0, 3'd0, 32'h0000_BBBB, 32'h0, 32'h0, 1'b1, 32'h77, 32'h88);
        for (int c = 1; c <= 3; c++) begin
            step();
            check($sformatf("stall_c%0d_rw", c),   {31'h0, RegWrite}, 32'h1);
            check($sformatf("stall_c%0d_wreg", c), {27'h0, WriteReg}, 32'd9);
            check($sformatf("stall_c%0d_data", c), RegData_out, 32'h0000_AAAA);
            check($sformatf("stall_c%0d_hi", c),   Hi, 32'h1);
        end
        Stall = 1'b0;
        nop();
        step();
        check("unstall_rw", {31'h0, RegWrite}, 32'h0);
        check("unstall_hi", Hi, 32'h55);
        check("unstall_lo", Lo, 32'h66);

        // Stall+Flush together: bubble wins, flushed mult never commits
        drive(1'b1, 1'b1, 5'd11, 3'd0, 3'd0, 32'h0000_CCCC, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        step();
        check("pre_flush_rw", {31'h0, RegWrite}, 32'h1);
        Stall = 1'b1; Flush = 1'b1;
        drive(1'b1, 1'b1, 5'd12, 3'd0, 3'd0, 32'h0000_DDDD, 32'h0, 32'h0, 1'b1, 32'h99, 32'h9A);
        step();
        check("flush_rw",   {31'h0, RegWrite}, 32'h0);
        check("flush_data", RegData_out, 32'h0);
        check("flush_wreg", {27'h0, WriteReg}, 32'h0);
        Stall = 1'b0; Flush = 1'b0;
        nop();
        step();
        check("flush_hi", Hi, 32'h55);
        check("flush_lo", Lo, 32'h66);

        // Asynchronous reset mid-stream with an ALU write to r5 in WB
        drive(1'b1, 1'b1, 5'd5, 3'd0, 3'd0, 32'h0000_CAFE, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        step();
        check("prerst_rw", {31'h0, RegWrite}, 32'h1);
        #2;
        Reset_n = 1'b0;
        #1;
        check("rst_rw",   {31'h0, RegWrite}, 32'h0);
        check("rst_data", RegData_out, 32'h0);
        check("rst_hi",   Hi, 32'h0);
        check("rst_lo",   Lo, 32'h0);
        @(negedge Clk);
        Reset_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Parametrised successor to the single-cycle WriteBack mux.
- Owns the MEM/WB pipeline register, selects the register-file write data from five sources (ALU, memory, link PC+4, HI, LO), and performs load byte/halfword alignment and extension.
- Holds the architectural HI/LO registers.
- Sits at the end of the 5-stage MIPS pipeline; its outputs feed both the register-file write port and the forwarding unit.

Parameters:
- DATA_W, 32, datapath width; the load-alignment lanes are defined for 32 only.
- REG_ADDR_W, 5, register-file address width.
- BIG_ENDIAN, 1, byte-lane order for sub-word loads (1 = MIPS big-endian).
- ZERO_REG_PROTECT, 1, when 1, writes to register 0 are suppressed.

Ports:
- Clk  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous, active-low reset.
- Stall  in  1  hold the WB register contents.
- Flush  in  1  load a bubble into the WB register.
- In_Valid  in  1  MEM-stage instruction valid.
- In_RegWrite  in  1  instruction writes the register file.
- In_WriteReg  in  REG_ADDR_W  destination register.
- In_WbSel  in  3  source select: 0 ALU, 1 MEM, 2 LINK, 3 HI, 4 LO.
- In_LoadType  in  3  load type: 0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU.
- In_AluResult  in  DATA_W  ALU result; bits [1:0] are the load byte offset.
- In_MemData  in  DATA_W  raw aligned memory word.
- In_PCPlusFour  in  DATA_W  link value for jal/jalr.
- In_HiLoWrite  in  1  instruction writes HI/LO (mult/div/mthi/mtlo).
- In_Hi, In_Lo  in  DATA_W  new HI/LO values.
- RegWrite  out  1  register-file write enable; also the forwarding qualifier.
- WriteReg  out  REG_ADDR_W  register-file write address.
- RegData_out  out  DATA_W  register-file write data.
- Hi, Lo  out  DATA_W  architectural HI/LO.

Behaviour:
- Reset (Reset_n=0, asynchronous): WB register cleared, including valid=0; HI=LO=0. Outputs during and after reset are RegWrite=0, WriteReg=0, RegData_out=0, Hi=Lo=0.
- Capture on each rising Clk edge:
  - Flush=1: load a bubble (valid=0, all fields 0). Flush beats Stall.
  - Otherwise Stall=1: hold the register.
  - Otherwise: load all In_* fields.
- Latency: a MEM-stage instruction appears on the outputs one cycle after capture. Outputs are combinational from the WB register only; there is no In_*-to-output path.
- RegWrite = valid & regwrite & legal WbSel (0..4) & !(ZERO_REG_PROTECT & WriteReg==0).
- Illegal WbSel (5..7): RegWrite=0 and RegData_out=0.
- Illegal LoadType with WbSel=MEM: treated as LW.
- RegData_out selection: ALU → alu_result; MEM → aligned load; LINK → pc_plus_four; HI → Hi register; LO → Lo register.
- Load alignment, with off = alu_result[1:0]:
  - Big-endian byte lanes: off 0 = [31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0]. BIG_ENDIAN=0 mirrors the lanes.
  - Halfwords use off[1] only (off 0 = [31:16], off 2 = [15:0]); off[0] is ignored because misalignment is trapped upstream.
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through, ignoring off.
- HI/LO update: at the rising edge that ends a valid WB-register entry with hilowrite=1, HI ← captured hi and LO ← captured lo.
  - A stalled entry updates HI/LO once only, on the edge it leaves WB.
  - A flushed entry never updates HI/LO.
  - mfhi/mflo in the cycle after a mult sees the new values without forwarding.
- RegWrite and HiLoWrite on the same entry are independent; both may be set.
- Stall held for N cycles: outputs remain constant for N+1 cycles, and RegWrite stays asserted (idempotent rewrite).

Decomposition:
- Package mips_wb_pkg: WbSel and LoadType encodings as localparams, and the default widths.
- One sub-module, load_align: combinational extractor taking word, offset and LoadType, parametrised by BIG_ENDIAN.
- The pipeline register, HI/LO registers and write-back select stay in writeback_unit.

Test Plan:
- Reset mid-stream:
  - Stimulus: assert Reset_n=0 while a valid ALU write to r5 is in WB.
  - Required: RegWrite=0, RegData_out=0 and Hi=Lo=0 immediately, without waiting for a clock edge.
- Load extension:
  - Stimulus: MemData=0x80FF7F01, WbSel=MEM, for each off/type pair.
  - Required: LB off0 → 0xFFFFFF80; LBU off0 → 0x00000080; LB off2 → 0x0000007F; LH off0 → 0xFFFF80FF; LHU off2 → 0x00007F01; LW → 0x80FF7F01.
- Link write:
  - Stimulus: jal with WbSel=LINK, PCPlusFour=0x00400024, WriteReg=31.
  - Required: one cycle later RegWrite=1, WriteReg=31, RegData_out=0x00400024.
- HI/LO timing:
  - Stimulus: mult with Hi=0x1, Lo=0xFFFFFFFE, followed next cycle by mfhi to r2.
  - Required: r2 data = 0x00000001, and Lo=0xFFFFFFFE thereafter.
- Stall/flush priority:
  - Stimulus: Stall and Flush asserted together.
  - Required: bubble loaded and RegWrite=0.
  - Stimulus: Stall held 3 cycles.
  - Required: outputs frozen for 4 cycles; HI/LO updated exactly once.
- Register-0 suppression:
  - Stimulus: WriteReg=0, RegWrite=1, ZERO_REG_PROTECT=1.
  - Required: RegWrite output = 0.
  - Stimulus: WbSel=6.
  - Required: RegWrite=0 and RegData_out=0.
